pipeline_scoreboard: RTL and testbench

Parametrised register scoreboard and hazard controller for the next-generation pipelined core. It replaces the fixed load-use check with per-register pending-result tracking, so functional units can have variable latency (multi-cycle load, multiply). It sits between decode and execute. It tells decode when to stall, tells execute which source operands come from the forwarding network, and squashes wrong-path entries when a branch is taken.

---
 rtl/pipeline_scoreboard.sv | 116 +++++++++++
 tb/tb_pipeline_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_scoreboard.sv
// Register scoreboard and hazard controller between decode and execute.
// Tracks pending results per register so functional units may have variable latency.
module pipeline_scoreboard #(
  parameter int NUM_REGS   = 16,
  parameter int REG_AW     = 4,
  parameter int LAT_W      = 3,
  parameter int AGE_W      = 3,
  parameter int FLUSH_SPAN = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic              fwd_rs1,
  output logic              fwd_rs2,
  output logic [REG_AW:0]   busy_count,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int DEPTH = 1 << REG_AW;
  localparam logic [LAT_W:0] MAX_LAT = (LAT_W+1)'((1 << LAT_W) - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [LAT_W-1:0]   cnt_q [DEPTH];
  logic [LAT_W-1:0]   cnt_d [DEPTH];
  logic [AGE_W-1:0]   age_q [DEPTH];
  logic [AGE_W-1:0]   age_d [DEPTH];
  logic [REG_AW:0]    busy_count_q, busy_count_d;
  logic [CNT_W-1:0]   stall_count_q;

  logic [LAT_W:0]     lat_wide;
  logic [LAT_W-1:0]   lat_e;
  logic               raw_rs1, raw_rs2, waw;

  // Clamp kept so a narrower MAX_LAT can be introduced without touching the hazard logic.
  assign lat_wide = {1'b0, id_lat};
  assign lat_e    = (lat_wide > MAX_LAT) ? MAX_LAT[LAT_W-1:0] : id_lat;

  assign raw_rs1 = id_rs1_used && (id_rs1 != '0) && busy_q[id_rs1] && (cnt_q[id_rs1] != '0);
  assign raw_rs2 = id_rs2_used && (id_rs2 != '0) && busy_q[id_rs2] && (cnt_q[id_rs2] != '0);
  assign waw     = id_rd_we && (id_rd != '0) && busy_q[id_rd] && (cnt_q[id_rd] > lat_e);

  assign stall   = id_valid && !flush && (raw_rs1 || raw_rs2 || waw);
  assign issue   = id_valid && !stall && !flush;
  assign fwd_rs1 = id_rs1_used && (id_rs1 != '0) && busy_q[id_rs1] && (cnt_q[id_rs1] == '0);
  assign fwd_rs2 = id_rs2_used && (id_rs2 != '0) && busy_q[id_rs2] && (cnt_q[id_rs2] == '0);

  // NOTE: blocking assignments in always_comb let later priority levels override
  // earlier ones; every target gets a default first so no latch is inferred.
  always_comb begin
    busy_d       = busy_q;
    busy_count_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      age_d[r] = age_q[r];
      if (r == 0 || r >= NUM_REGS) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = '0;
        age_d[r]  = '0;
      end else begin
        // Lowest to highest priority: aging, writeback, flush, issue.
        if (busy_q[r]) begin
          if (cnt_q[r] != '0)     cnt_d[r] = cnt_q[r] - 1'b1;
          if (age_q[r] != AGE_MAX) age_d[r] = age_q[r] + 1'b1;
        end
        if (wb_valid && (wb_rd == REG_AW'(r))) busy_d[r] = 1'b0;
        if (flush && busy_q[r] && (int'(age_q[r]) < FLUSH_SPAN)) busy_d[r] = 1'b0;
        if (issue && id_rd_we && (id_rd == REG_AW'(r))) begin
          busy_d[r] = 1'b1;
          cnt_d[r]  = lat_e;
          age_d[r]  = '0;
        end
      end
      busy_count_d = busy_count_d + {{REG_AW{1'b0}}, busy_d[r]};
    end
  end

  // NOTE: the per-register arrays are plain flops, not a RAM macro, so every
  // entry is reset; no stale busy bit may survive reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q        <= '0;
      busy_count_q  <= '0;
      stall_count_q <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= '0;
        age_q[r] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= cnt_d[r];
        age_q[r] <= age_d[r];
      end
      if (stall && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign busy_count  = busy_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed scenarios plus random
// traffic, all compared against a behavioural scoreboard model.
module tb_pipeline_scoreboard;

  localparam int NR = 16;
  localparam int AW = 4;
  localparam int LW = 3;
  localparam int CW = 32;
  localparam int MAXLAT = 7;
  localparam int AGEMAX = 7;
  localparam int FSPAN = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic          id_rs1_used, id_rs2_used, id_rd_we, wb_valid, flush;
  logic [LW-1:0] id_lat;
  logic          stall, issue, fwd_rs1, fwd_rs2;
  logic [AW:0]   busy_count;
  logic [CW-1:0] stall_count;

  pipeline_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat(id_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .issue(issue), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .busy_count(busy_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: for each register, whether a result is pending, cycles left until
  // it can be forwarded, and cycles since issue.
  bit     m_pending [NR];
  int     m_left    [NR];
  int     m_since   [NR];
  longint m_stalls;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < NR; r++) begin
      m_pending[r] = 0; m_left[r] = 0; m_since[r] = 0;
    end
    m_stalls = 0;
  endfunction

  function automatic bit m_waiting(int s, bit used);
    return used && s != 0 && m_pending[s] && m_left[s] > 0;
  endfunction

  function automatic bit m_ready(int s, bit used);
    return used && s != 0 && m_pending[s] && m_left[s] == 0;
  endfunction

  function automatic int m_lat();
    return (int'(id_lat) > MAXLAT) ? MAXLAT : int'(id_lat);
  endfunction

  function automatic bit m_stall();
    bit waw = id_rd_we && id_rd != 0 && m_pending[id_rd] && m_left[id_rd] > m_lat();
    return id_valid && !flush &&
           (m_waiting(int'(id_rs1), id_rs1_used) || m_waiting(int'(id_rs2), id_rs2_used) || waw);
  endfunction

  function automatic int m_busy_total();
    int n = 0;
    for (int r = 1; r < NR; r++) n += int'(m_pending[r]);
    return n;
  endfunction

  function automatic void m_clock();
    bit st  = m_stall();
    bit iss = id_valid && !st && !flush;
    int since_pre [NR];
    for (int r = 0; r < NR; r++) since_pre[r] = m_since[r];
    if (st && m_stalls != 64'hFFFF_FFFF) m_stalls++;
    for (int r = 1; r < NR; r++) begin
      if (m_pending[r]) begin
        m_left[r]  = (m_left[r] > 0) ? m_left[r] - 1 : 0;
        m_since[r] = (m_since[r] < AGEMAX) ? m_since[r] + 1 : AGEMAX;
      end
      if (flush && m_pending[r] && since_pre[r] < FSPAN) m_pending[r] = 0;
      if (wb_valid && int'(wb_rd) == r) m_pending[r] = 0;
      if (iss && id_rd_we && int'(id_rd) == r) begin
        m_pending[r] = 1; m_left[r] = m_lat(); m_since[r] = 0;
      end
    end
  endfunction

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input int lat,
                       input bit wbv, input int wbr, input bit fl);
    id_valid = v; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2); id_rs2_used = u2;
    id_rd = AW'(rd); id_rd_we = we; id_lat = LW'(lat);
    wb_valid = wbv; wb_rd = AW'(wbr); flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    chk({tag, " stall"}, stall, m_stall());
    chk({tag, " issue"}, issue, id_valid && !m_stall() && !flush);
    chk({tag, " fwd_rs1"}, fwd_rs1, m_ready(int'(id_rs1), id_rs1_used));
    chk({tag, " fwd_rs2"}, fwd_rs2, m_ready(int'(id_rs2), id_rs2_used));
    @(posedge clk);
    m_clock();
    #1;
    chk({tag, " busy_count"}, busy_count, m_busy_total());
    chk({tag, " stall_count"}, stall_count, m_stalls);
  endtask

  initial begin
    m_reset();
    reset_n = 1'b0;
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("por busy_count", busy_count, 0);
    chk("por stall_count", stall_count, 0);
    chk("por stall", stall, 0);
    chk("por issue", issue, 1);
    chk("por fwd_rs1", fwd_rs1, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset with an entry busy.
    drive(1, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0);
    cycle("rst_issue_r3");
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst busy_count", busy_count, 0);
    chk("rst stall", stall, 0);
    chk("rst stall_count", stall_count, 0);
    chk("rst fwd_rs1", fwd_rs1, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle();
    cycle("post_rst_idle");

    // Load-use: one stall, then forward.
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    cycle("lu_issue");
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lu stall_now", stall, 1);
    cycle("lu_stall");
    #1 chk("lu fwd_now", fwd_rs1, 1);
    chk("lu no_stall", stall, 0);
    cycle("lu_fwd");
    chk("lu stall_count", stall_count, 1);

    // ALU back-to-back: latency 0 forwards with no stall.
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    cycle("alu_issue");
    drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("alu stall", stall, 0);
    chk("alu fwd_rs2", fwd_rs2, 1);
    cycle("alu_use");

    // WAW: the short-latency write waits until the long one can no longer land after it.
    drive(1, 0, 0, 0, 0, 7, 1, 4, 0, 0, 0);
    cycle("waw_first");
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle("waw_second");

    // Flush: young entry r6 squashed, older r4 kept; the flushing instruction does not issue.
    idle();
    for (int i = 0; i < 4; i++) cycle("drain");
    drive(1, 0, 0, 0, 0, 4, 1, 3, 0, 0, 0);
    cycle("fl_issue_r4");
    idle();
    cycle("fl_gap1");
    cycle("fl_gap2");
    drive(1, 0, 0, 0, 0, 6, 1, 3, 0, 0, 0);
    cycle("fl_issue_r6");
    drive(1, 0, 0, 0, 0, 8, 1, 2, 0, 0, 1);
    cycle("fl_flush");
    chk("fl r4_kept", dut.busy_q[4], 1);
    chk("fl r6_squashed", dut.busy_q[6], 0);
    chk("fl r8_not_issued", dut.busy_q[8], 0);

    // Writeback and issue on the same register: issue wins.
    drive(1, 0, 0, 0, 0, 9, 1, 5, 0, 0, 0);
    cycle("sim_issue_r9");
    idle();
    for (int i = 0; i < 5; i++) cycle("sim_wait");
    drive(1, 0, 0, 0, 0, 9, 1, 2, 1, 9, 0);
    cycle("sim_wb_issue_r9");
    chk("sim r9_busy", dut.busy_q[9], 1);
    chk("sim r9_cnt", dut.cnt_q[9], 2);

    // Register 0: writes ignored, reads never stall.
    drive(1, 0, 1, 0, 1, 0, 1, 7, 0, 0, 0);
    #1 chk("r0 stall", stall, 0);
    cycle("r0_write");
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cycle("r0_read");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, NR-1), $urandom_range(0, 1),
            $urandom_range(0, NR-1), $urandom_range(0, 1),
            $urandom_range(0, NR-1), $urandom_range(0, 3) != 0, $urandom_range(0, MAXLAT),
            $urandom_range(0, 2) == 0, $urandom_range(0, NR-1), $urandom_range(0, 9) == 0);
      cycle("rand");
    end

    idle();
    cycle("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
